// File: rtl/rr_arb_5.sv
// rr_arb_5: five-way round-robin arbiter with a registered one-hot grant held until the owner releases.
// Define ARB_TIMEOUT_EN to compile in the hold-timeout revoke (MAX_HOLD cycles) and the requester mask.
module rr_arb_5 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] req,
    output logic [4:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [4:0] eligible;
    logic       pick_valid;
    logic [2:0] pick_id;
    logic [2:0] next_ptr;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_arb_5: MAX_HOLD must be in 2..255");
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;
    logic [4:0] mask;
    assign eligible = req & ~mask;
`else
    assign eligible = req;
`endif

    // First eligible requester searching upward from ptr, wrapping at 5.
    always_comb begin
        int idx;
        pick_valid = 1'b0;
        pick_id    = 3'd0;
        idx        = 0;
        for (int k = 0; k < 5; k++) begin
            idx = (int'(ptr) + k) % 5;
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_id    = 3'(idx);
            end
        end
    end

    assign next_ptr = (gnt_id == 3'd4) ? 3'd0 : gnt_id + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 5'b0;
            gnt_id  <= 3'd0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            ptr     <= 3'd0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
            mask     <= 5'b0;
`endif
        end else begin
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            mask <= mask & req;
`endif
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt    <= 5'b00001 << pick_id;
                        gnt_id <= pick_id;
                        busy   <= 1'b1;
                        state  <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        gnt    <= 5'b0;
                        gnt_id <= 3'd0;
                        busy   <= 1'b0;
                        ptr    <= next_ptr;
                        state  <= IDLE;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt == HOLD_LAST) begin
                        // Revoke: owner stays masked until it drops its request.
                        gnt     <= 5'b0;
                        gnt_id  <= 3'd0;
                        busy    <= 1'b0;
                        ptr     <= next_ptr;
                        state   <= IDLE;
                        timeout <= 1'b1;
                        mask    <= (mask & req) | (5'b00001 << gnt_id);
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arb_5.sv
// Testbench for rr_arb_5: directed scenarios plus random traffic against a cycle-level reference model.
module tb_rr_arb_5;
    localparam int MAX_HOLD = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = 5'b0;
    logic [4:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: current owner (-1 idle), search start, cycles granted so far, masked requesters.
    int       m_owner = -1;
    int       m_ptr   = 0;
    int       m_held  = 0;
    bit [4:0] m_mask  = 5'b0;
    bit       m_to    = 1'b0;

    always #5 clk = ~clk;

    rr_arb_5 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
    );

    task automatic model_edge(input logic [4:0] r, input logic rs);
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_mask = 5'b0; m_to = 1'b0;
            return;
        end
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 5; k++) begin
                int i = (m_ptr + k) % 5;
                if (r[i] && !m_mask[i]) begin
                    m_owner = i;
                    m_held  = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 5;
            m_owner = -1;
        end else if (TO_EN && m_held >= MAX_HOLD) begin
            m_mask[m_owner] = 1'b1;
            m_ptr   = (m_owner + 1) % 5;
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
        end
        m_mask &= r;
    endtask

    function automatic logic [9:0] exp_vec();
        logic [4:0] g;
        logic [2:0] id;
        g  = (m_owner >= 0) ? 5'(1 << m_owner) : 5'b0;
        id = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
        return {g, id, |g, m_to};
    endfunction

    task automatic step(input logic [4:0] r, input logic rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_edge(r, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            step(5'b11111, 1'b1);
            vectors++;
            if ({gnt, gnt_id, busy, timeout} !== 10'b0) begin
                miscompares++;
                $display("FAIL reset_state got {gnt,id,busy,to}=%b want %b", {gnt, gnt_id, busy, timeout}, 10'b0);
            end
        end
        step(5'b11111, 1'b0);
        vectors++;
        if (gnt !== 5'b00001 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_grant got gnt=%b busy=%b want gnt=00001 busy=1", gnt, busy);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int exp_order[6] = '{0, 1, 2, 3, 4, 0};
        int prev_owner;
        logic [4:0] r;
        step(5'b11111, 1'b1);
        for (int c = 0; c < 80 && order.size() < 6; c++) begin
            r = 5'b11111;
            if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
            prev_owner = m_owner;
            step(r, 1'b0);
            vectors++;
            if ({gnt, gnt_id, busy, timeout} !== exp_vec()) begin
                miscompares++;
                $display("FAIL rotation cyc=%0d got %b want %b", c, {gnt, gnt_id, busy, timeout}, exp_vec());
            end
            if (prev_owner < 0 && m_owner >= 0) order.push_back(m_owner);
        end
        vectors++;
        if (order.size() != 6) begin
            miscompares++;
            $display("FAIL rotation_count got %0d grants want 6", order.size());
        end
        for (int i = 0; i < order.size() && i < 6; i++) begin
            vectors++;
            if (order[i] != exp_order[i]) begin
                miscompares++;
                $display("FAIL rotation_order idx=%0d got %0d want %0d", i, order[i], exp_order[i]);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        step(5'b00000, 1'b1);
        step(5'b01000, 1'b0);
        step(5'b01000, 1'b0);
        step(5'b00000, 1'b0);
        step(5'b00101, 1'b0);
        vectors++;
        if (gnt !== 5'b00001 || gnt_id !== 3'd0 || {gnt, gnt_id, busy, timeout} !== exp_vec()) begin
            miscompares++;
            $display("FAIL pointer_wrap got gnt=%b id=%0d want gnt=00001 id=0", gnt, gnt_id);
        end
    endtask

`ifndef ARB_TIMEOUT_EN
    task automatic test_hold();
        step(5'b00000, 1'b1);
        step(5'b00010, 1'b0);
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if (gnt !== 5'b00010 || timeout !== 1'b0) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got gnt=%b to=%b want gnt=00010 to=0", c, gnt, timeout);
            end
            step(5'b00010, 1'b0);
        end
    endtask
`endif

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        int g0 = 0;
        int pulses = 0;
        step(5'b00000, 1'b1);
        for (int c = 0; c < 40; c++) begin
            step(5'b00011, 1'b0);
            if (gnt == 5'b00001) g0++;
            if (timeout) pulses++;
            vectors++;
            if ({gnt, gnt_id, busy, timeout} !== exp_vec()) begin
                miscompares++;
                $display("FAIL timeout cyc=%0d got %b want %b", c, {gnt, gnt_id, busy, timeout}, exp_vec());
            end
        end
        vectors++;
        if (g0 != MAX_HOLD || pulses != 2) begin
            miscompares++;
            $display("FAIL timeout_counts got g0=%0d pulses=%0d want g0=%0d pulses=2", g0, pulses, MAX_HOLD);
        end
        step(5'b00010, 1'b0);
        step(5'b00011, 1'b0);
        vectors++;
        if (gnt !== 5'b00001) begin
            miscompares++;
            $display("FAIL timeout_unmask got gnt=%b want 00001", gnt);
        end
    endtask
`endif

    task automatic test_reset_mid_grant();
        step(5'b00000, 1'b1);
        step(5'b00100, 1'b0);
        step(5'b00100, 1'b0);
        vectors++;
        if (gnt !== 5'b00100) begin
            miscompares++;
            $display("FAIL mid_reset_pre got gnt=%b want 00100", gnt);
        end
        step(5'b00100, 1'b1);
        vectors++;
        if (gnt !== 5'b00000 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_clear got gnt=%b busy=%b want 00000 0", gnt, busy);
        end
        step(5'b10101, 1'b0);
        vectors++;
        if (gnt !== 5'b00001 || {gnt, gnt_id, busy, timeout} !== exp_vec()) begin
            miscompares++;
            $display("FAIL mid_reset_search got gnt=%b want 00001", gnt);
        end
    endtask

    task automatic test_random();
        logic [4:0] r = 5'b0;
        logic       rs;
        step(5'b00000, 1'b1);
        for (int c = 0; c < 600; c++) begin
            r  = r ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            rs = ($urandom_range(0, 63) == 0);
            step(r, rs);
            vectors++;
            if ({gnt, gnt_id, busy, timeout} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d req=%b got %b want %b", c, r, {gnt, gnt_id, busy, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_pointer_wrap();
`ifndef ARB_TIMEOUT_EN
        test_hold();
`else
        test_timeout();
`endif
        test_reset_mid_grant();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
